alpha_beta_predictor_core: RTL and testbench

//  Alpha-beta tracking predictor datapath driven by the 4-phase trigger sequencer:

---
 rtl/alpha_beta_predictor_core.sv | 177 +++++++++++++++++
 tb/tb_alpha_beta_predictor_core.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alpha_beta_predictor_core.sv
// Alpha-beta tracking predictor: latch -> update -> predict -> output phases,
// each advanced by a single-cycle trigger strobe.
module alpha_beta_predictor_core #(
    parameter int DATA_W      = 16,
    parameter int ALPHA_SHIFT = 2,
    parameter int BETA_SHIFT  = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     latch_trigger,
    input  logic                     update_trigger,
    input  logic                     predict_trigger,
    input  logic                     output_trigger,
    input  logic signed [DATA_W-1:0] meas_in,
    input  logic                     meas_valid,
    output logic signed [DATA_W-1:0] pred_out,
    output logic                     pred_valid,
    output logic signed [DATA_W:0]   residual_out,
    output logic                     sat_flag,
    output logic                     seq_error
);

    localparam int SW = DATA_W + 2;
    localparam logic signed [SW-1:0] MAX_V = {3'b000, {(DATA_W-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_V = {3'b111, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        WAIT_LATCH,
        WAIT_UPDATE,
        WAIT_PRED,
        WAIT_OUT
    } state_t;

    state_t                    state_q, state_d;
    logic signed [DATA_W-1:0]  z_q, z_d;
    logic                      zv_q, zv_d;
    logic                      init_done_q, init_done_d;
    logic signed [DATA_W-1:0]  x_est_q, x_est_d;
    logic signed [DATA_W-1:0]  v_est_q, v_est_d;
    logic signed [DATA_W-1:0]  x_pred_q, x_pred_d;
    logic signed [DATA_W-1:0]  pred_out_q, pred_out_d;
    logic                      pred_valid_q, pred_valid_d;
    logic signed [DATA_W:0]    residual_q, residual_d;
    logic                      sat_flag_q, sat_flag_d;
    logic                      seq_error_q, seq_error_d;

    logic signed [DATA_W:0]    resid;
    logic signed [DATA_W:0]    r_alpha;
    logic signed [DATA_W:0]    r_beta;
    logic signed [SW-1:0]      est_sum;
    logic signed [SW-1:0]      vel_sum;
    logic signed [SW-1:0]      pred_sum;
    logic                      multi_strobe;

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [SW-1:0] v);
        if (v > MAX_V)      sat = {1'b0, {(DATA_W-1){1'b1}}};
        else if (v < MIN_V) sat = {1'b1, {(DATA_W-1){1'b0}}};
        else                sat = v[DATA_W-1:0];
    endfunction

    function automatic logic clamps(input logic signed [SW-1:0] v);
        clamps = (v > MAX_V) || (v < MIN_V);
    endfunction

    always_comb begin
        resid    = {z_q[DATA_W-1], z_q} - {x_pred_q[DATA_W-1], x_pred_q};
        r_alpha  = resid >>> ALPHA_SHIFT;
        r_beta   = resid >>> BETA_SHIFT;
        est_sum  = {{2{x_pred_q[DATA_W-1]}}, x_pred_q} + {r_alpha[DATA_W], r_alpha};
        vel_sum  = {{2{v_est_q[DATA_W-1]}}, v_est_q} + {r_beta[DATA_W], r_beta};
        pred_sum = {{2{x_est_q[DATA_W-1]}}, x_est_q} + {{2{v_est_q[DATA_W-1]}}, v_est_q};
        multi_strobe = $countones({latch_trigger, update_trigger,
                                   predict_trigger, output_trigger}) > 1;
    end

    always_comb begin
        state_d      = state_q;
        z_d          = z_q;
        zv_d         = zv_q;
        init_done_d  = init_done_q;
        x_est_d      = x_est_q;
        v_est_d      = v_est_q;
        x_pred_d     = x_pred_q;
        pred_out_d   = pred_out_q;
        pred_valid_d = 1'b0;
        residual_d   = residual_q;
        sat_flag_d   = sat_flag_q;
        seq_error_d  = seq_error_q;

        if (multi_strobe) begin
            seq_error_d = 1'b1;
            state_d     = WAIT_LATCH;
        end else if (latch_trigger) begin
            // A lone latch is always honoured; outside WAIT_LATCH it is a resync.
            z_d     = meas_in;
            zv_d    = meas_valid;
            state_d = WAIT_UPDATE;
            if (state_q != WAIT_LATCH) seq_error_d = 1'b1;
        end else if (update_trigger) begin
            if (state_q == WAIT_UPDATE) begin
                state_d = WAIT_PRED;
                if (zv_q && !init_done_q) begin
                    x_est_d     = z_q;
                    v_est_d     = '0;
                    residual_d  = '0;
                    init_done_d = 1'b1;
                end else if (zv_q) begin
                    residual_d = resid;
                    x_est_d    = sat(est_sum);
                    v_est_d    = sat(vel_sum);
                    if (clamps(est_sum) || clamps(vel_sum)) sat_flag_d = 1'b1;
                end else begin
                    residual_d = '0;
                    if (init_done_q) x_est_d = x_pred_q;
                end
            end else begin
                seq_error_d = 1'b1;
                state_d     = WAIT_LATCH;
            end
        end else if (predict_trigger) begin
            if (state_q == WAIT_PRED) begin
                state_d  = WAIT_OUT;
                x_pred_d = sat(pred_sum);
                if (clamps(pred_sum)) sat_flag_d = 1'b1;
            end else begin
                seq_error_d = 1'b1;
                state_d     = WAIT_LATCH;
            end
        end else if (output_trigger) begin
            if (state_q == WAIT_OUT) begin
                state_d      = WAIT_LATCH;
                pred_out_d   = x_pred_q;
                pred_valid_d = init_done_q;
            end else begin
                seq_error_d = 1'b1;
                state_d     = WAIT_LATCH;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= WAIT_LATCH;
            z_q          <= '0;
            zv_q         <= 1'b0;
            init_done_q  <= 1'b0;
            x_est_q      <= '0;
            v_est_q      <= '0;
            x_pred_q     <= '0;
            pred_out_q   <= '0;
            pred_valid_q <= 1'b0;
            residual_q   <= '0;
            sat_flag_q   <= 1'b0;
            seq_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            z_q          <= z_d;
            zv_q         <= zv_d;
            init_done_q  <= init_done_d;
            x_est_q      <= x_est_d;
            v_est_q      <= v_est_d;
            x_pred_q     <= x_pred_d;
            pred_out_q   <= pred_out_d;
            pred_valid_q <= pred_valid_d;
            residual_q   <= residual_d;
            sat_flag_q   <= sat_flag_d;
            seq_error_q  <= seq_error_d;
        end
    end

    assign pred_out     = pred_out_q;
    assign pred_valid   = pred_valid_q;
    assign residual_out = residual_q;
    assign sat_flag     = sat_flag_q;
    assign seq_error    = seq_error_q;

endmodule

// File: tb/tb_alpha_beta_predictor_core.sv
// Bench for alpha_beta_predictor_core: directed phase scenarios plus randomized
// strobe/measurement traffic against an integer reference model.
module tb_alpha_beta_predictor_core;

    localparam int DW = 16;
    localparam int A  = 1;
    localparam int B  = 2;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 latch_trigger = 1'b0;
    logic                 update_trigger = 1'b0;
    logic                 predict_trigger = 1'b0;
    logic                 output_trigger = 1'b0;
    logic signed [DW-1:0] meas_in = '0;
    logic                 meas_valid = 1'b0;
    logic signed [DW-1:0] pred_out;
    logic                 pred_valid;
    logic signed [DW:0]   residual_out;
    logic                 sat_flag;
    logic                 seq_error;

    int checks = 0;
    int errors = 0;

    // Reference model state (plain integers, phase counter 0..3)
    int m_phase, m_z, m_xe, m_ve, m_xp, m_po, m_res;
    bit m_zv, m_init, m_pv, m_sat, m_err;

    always #5 clock = ~clock;

    alpha_beta_predictor_core #(
        .DATA_W(DW),
        .ALPHA_SHIFT(A),
        .BETA_SHIFT(B)
    ) dut (
        .clock(clock),
        .reset(reset),
        .latch_trigger(latch_trigger),
        .update_trigger(update_trigger),
        .predict_trigger(predict_trigger),
        .output_trigger(output_trigger),
        .meas_in(meas_in),
        .meas_valid(meas_valid),
        .pred_out(pred_out),
        .pred_valid(pred_valid),
        .residual_out(residual_out),
        .sat_flag(sat_flag),
        .seq_error(seq_error)
    );

    function automatic int clampv(input int v, output bit hit);
        hit = (v > 32767) || (v < -32768);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_z = 0; m_xe = 0; m_ve = 0; m_xp = 0; m_po = 0; m_res = 0;
        m_zv = 0; m_init = 0; m_pv = 0; m_sat = 0; m_err = 0;
    endtask

    // s = {latch, update, predict, output}
    task automatic model_step(input logic [3:0] s, input int meas, input bit mv);
        bit h;
        int r;
        m_pv = 0;
        if ($countones(s) > 1) begin
            m_err = 1; m_phase = 0;
        end else if (s[3]) begin
            if (m_phase != 0) m_err = 1;
            m_z = meas; m_zv = mv; m_phase = 1;
        end else if (s[2]) begin
            if (m_phase == 1) begin
                if (m_zv && !m_init) begin
                    m_xe = m_z; m_ve = 0; m_res = 0; m_init = 1;
                end else if (m_zv) begin
                    r = m_z - m_xp;
                    m_res = r;
                    m_xe = clampv(m_xp + (r >>> A), h); if (h) m_sat = 1;
                    m_ve = clampv(m_ve + (r >>> B), h); if (h) m_sat = 1;
                end else begin
                    m_res = 0;
                    if (m_init) m_xe = m_xp;
                end
                m_phase = 2;
            end else begin
                m_err = 1; m_phase = 0;
            end
        end else if (s[1]) begin
            if (m_phase == 2) begin
                m_xp = clampv(m_xe + m_ve, h); if (h) m_sat = 1;
                m_phase = 3;
            end else begin
                m_err = 1; m_phase = 0;
            end
        end else if (s[0]) begin
            if (m_phase == 3) begin
                m_po = m_xp; m_pv = m_init; m_phase = 0;
            end else begin
                m_err = 1; m_phase = 0;
            end
        end
    endtask

    // Drive one cycle on the falling edge; returns 1 time unit after the rising edge.
    task automatic tick(input logic [3:0] s, input int meas, input bit mv);
        @(negedge clock);
        {latch_trigger, update_trigger, predict_trigger, output_trigger} = s;
        meas_in    = 16'(meas);
        meas_valid = mv;
        @(posedge clock);
        model_step(s, meas, mv);
        #1;
    endtask

    task automatic full_cycle(input int meas, input bit mv);
        tick(4'b1000, meas, mv);
        tick(4'b0100, 0, 0);
        tick(4'b0010, 0, 0);
        tick(4'b0001, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        {latch_trigger, update_trigger, predict_trigger, output_trigger} = 4'b0000;
        @(posedge clock);
        model_reset();
        #1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (pred_out !== 16'sd0) begin errors++; $display("FAIL reset_pred_out got %0d want 0", pred_out); end
        if (pred_valid !== 1'b0) begin errors++; $display("FAIL reset_pred_valid got %b want 0", pred_valid); end
        if (residual_out !== 17'sd0) begin errors++; $display("FAIL reset_residual got %0d want 0", residual_out); end
        if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat got %b want 0", sat_flag); end
        if (seq_error !== 1'b0) begin errors++; $display("FAIL reset_seq_error got %b want 0", seq_error); end
    endtask

    task automatic test_init();
        full_cycle(100, 1);
        checks += 3;
        if (pred_out !== 16'sd100) begin errors++; $display("FAIL init_pred_out got %0d want 100", pred_out); end
        if (pred_valid !== 1'b1) begin errors++; $display("FAIL init_pred_valid got %b want 1", pred_valid); end
        if (residual_out !== 17'sd0) begin errors++; $display("FAIL init_residual got %0d want 0", residual_out); end
        tick(4'b0000, 0, 0);
        checks++;
        if (pred_valid !== 1'b0) begin errors++; $display("FAIL init_pulse_width got %b want 0", pred_valid); end
    endtask

    task automatic test_track();
        full_cycle(120, 1);
        checks += 3;
        if (residual_out !== 17'sd20) begin errors++; $display("FAIL track1_residual got %0d want 20", residual_out); end
        if (pred_out !== 16'sd115) begin errors++; $display("FAIL track1_pred_out got %0d want 115", pred_out); end
        if (pred_valid !== 1'b1) begin errors++; $display("FAIL track1_pred_valid got %b want 1", pred_valid); end
        tick(4'b0000, 0, 0);
        tick(4'b0000, 0, 0);
        full_cycle(130, 1);
        checks += 3;
        if (residual_out !== 17'sd15) begin errors++; $display("FAIL track2_residual got %0d want 15", residual_out); end
        if (pred_out !== 16'sd130) begin errors++; $display("FAIL track2_pred_out got %0d want 130", pred_out); end
        if (seq_error !== 1'b0) begin errors++; $display("FAIL track2_seq_error got %b want 0", seq_error); end
    endtask

    task automatic test_coast();
        full_cycle(int'($urandom_range(0, 2000)), 0);
        checks += 4;
        if (residual_out !== 17'sd0) begin errors++; $display("FAIL coast_residual got %0d want 0", residual_out); end
        if (pred_out !== 16'sd138) begin errors++; $display("FAIL coast_pred_out got %0d want 138", pred_out); end
        if (pred_valid !== 1'b1) begin errors++; $display("FAIL coast_pred_valid got %b want 1", pred_valid); end
        if (seq_error !== 1'b0) begin errors++; $display("FAIL coast_seq_error got %b want 0", seq_error); end
    endtask

    task automatic test_saturate();
        int exp_po [3] = '{32766, 32767, 32767};
        bit exp_sat [3] = '{1'b0, 1'b0, 1'b1};
        do_reset();
        full_cycle(32760, 1);
        full_cycle(32767, 1);
        checks += 3;
        if (residual_out !== 17'sd7) begin errors++; $display("FAIL sat_residual got %0d want 7", residual_out); end
        if (pred_out !== 16'sd32764) begin errors++; $display("FAIL sat_first_pred got %0d want 32764", pred_out); end
        if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_early got %b want 0", sat_flag); end
        for (int i = 0; i < 3; i++) begin
            full_cycle(32767, 1);
            checks += 2;
            if ($signed(pred_out) !== exp_po[i]) begin errors++; $display("FAIL sat_pred[%0d] got %0d want %0d", i, pred_out, exp_po[i]); end
            if (sat_flag !== exp_sat[i]) begin errors++; $display("FAIL sat_flag[%0d] got %b want %b", i, sat_flag, exp_sat[i]); end
        end
        full_cycle(-32768, 0);
        checks++;
        if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_sticky got %b want 1", sat_flag); end
    endtask

    task automatic test_order();
        do_reset();
        tick(4'b0010, 0, 0);
        checks += 2;
        if (seq_error !== 1'b1) begin errors++; $display("FAIL order_bad_strobe got %b want 1", seq_error); end
        if (pred_valid !== 1'b0) begin errors++; $display("FAIL order_no_valid got %b want 0", pred_valid); end
        full_cycle(200, 1);
        checks++;
        if (pred_out !== 16'sd200) begin errors++; $display("FAIL order_init got %0d want 200", pred_out); end
        tick(4'b1000, 210, 1);
        tick(4'b0110, 0, 0);
        tick(4'b0100, 0, 0);
        full_cycle(220, 1);
        checks += 3;
        if (residual_out !== 17'sd20) begin errors++; $display("FAIL order_overlap_residual got %0d want 20", residual_out); end
        if (pred_out !== 16'sd215) begin errors++; $display("FAIL order_overlap_pred got %0d want 215", pred_out); end
        if (seq_error !== 1'b1) begin errors++; $display("FAIL order_sticky got %b want 1", seq_error); end
        tick(4'b1000, 230, 1);
        tick(4'b0100, 0, 0);
        full_cycle(240, 1);
        checks += 3;
        if (residual_out !== 17'sd25) begin errors++; $display("FAIL resync_residual got %0d want 25", residual_out); end
        if (pred_out !== 16'sd241) begin errors++; $display("FAIL resync_pred got %0d want 241", pred_out); end
        if (pred_valid !== 1'b1) begin errors++; $display("FAIL resync_valid got %b want 1", pred_valid); end
        full_cycle(250, 1);
        checks += 2;
        if (residual_out !== 17'sd9) begin errors++; $display("FAIL resync_next_residual got %0d want 9", residual_out); end
        if (pred_out !== 16'sd261) begin errors++; $display("FAIL resync_next_pred got %0d want 261", pred_out); end
    endtask

    task automatic test_reset_mid();
        tick(4'b1000, 300, 1);
        tick(4'b0100, 0, 0);
        do_reset();
        checks += 4;
        if (pred_out !== 16'sd0) begin errors++; $display("FAIL midreset_pred got %0d want 0", pred_out); end
        if (pred_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b want 0", pred_valid); end
        if (residual_out !== 17'sd0) begin errors++; $display("FAIL midreset_residual got %0d want 0", residual_out); end
        if (seq_error !== 1'b0) begin errors++; $display("FAIL midreset_seq_error got %b want 0", seq_error); end
        full_cycle(-500, 1);
        checks += 3;
        if (pred_out !== -16'sd500) begin errors++; $display("FAIL reinit_pred got %0d want -500", pred_out); end
        if (pred_valid !== 1'b1) begin errors++; $display("FAIL reinit_valid got %b want 1", pred_valid); end
        if (residual_out !== 17'sd0) begin errors++; $display("FAIL reinit_residual got %0d want 0", residual_out); end
    endtask

    task automatic test_random();
        logic [3:0] s;
        int meas;
        int sel;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 70)      s = 4'b1000 >> m_phase;
            else if (sel < 82) s = 4'b0000;
            else               s = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) meas = int'($urandom_range(0, 65535)) - 32768;
            else                           meas = int'($urandom_range(0, 4000)) - 2000;
            tick(s, meas, $urandom_range(0, 4) != 0);
            checks += 5;
            if ($signed(pred_out) !== m_po) begin errors++; $display("FAIL rand_pred_out[%0d] got %0d want %0d", i, pred_out, m_po); end
            if (pred_valid !== m_pv) begin errors++; $display("FAIL rand_pred_valid[%0d] got %b want %b", i, pred_valid, m_pv); end
            if ($signed(residual_out) !== m_res) begin errors++; $display("FAIL rand_residual[%0d] got %0d want %0d", i, residual_out, m_res); end
            if (sat_flag !== m_sat) begin errors++; $display("FAIL rand_sat[%0d] got %b want %b", i, sat_flag, m_sat); end
            if (seq_error !== m_err) begin errors++; $display("FAIL rand_seq_error[%0d] got %b want %b", i, seq_error, m_err); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_init();
        test_track();
        test_coast();
        test_saturate();
        test_order();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
